irrigation_actuator_drv: RTL
============================

// Module: irrigation_actuator_drv
// PURPOSE
//  Actuator end of the irrigation command interface: consumes level requests Bs (sprinkler pump)
//  and Vs (drip valve) from the irrigation decision logic and drives the physical actuators.
//  Enforces pump/valve mutual exclusion, minimum on-time, changeover dead-time and a flow watchdog.
//  Returns the ERRO fault flag to the decision logic, closing the loop.
// PARAMETERS
//  MIN_ON   8   minimum cycles an actuator stays on once started (>=1)
//  DEAD_T   4   all-off cycles after any actuator turns off (>=1)
//  FLOW_TO  16  consecutive no-flow cycles while active before fault (>=1)
// PORTS
//  clk      in   1  system clock, all state on rising edge
//  reset    in   1  asynchronous, active-high reset
//  Bs       in   1  pump request from decision logic (async level)
//  Vs       in   1  valve request from decision logic (async level)
//  FLOW     in   1  flow sensor, 1 = water flowing (async level)
//  CLR      in   1  fault clear, synchronous, sampled directly (no synchronizer)
//  PUMP_ON  out  1  sprinkler pump drive
//  VALVE_ON out  1  drip valve drive
//  ERRO     out  1  latched fault flag
//  ST       out  3  state code: IDLE=0 PUMP=1 VALVE=2 DEAD=3 FAULT=4
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high. On reset: state IDLE, all counters 0,
//    synchronizers 0, PUMP_ON=0, VALVE_ON=0, ERRO=0, ST=0.
//  - Bs, Vs, FLOW each pass a 2-FF synchronizer (bs_s, vs_s, flow_s); 2-cycle input latency.
//  - Outputs are registered state decodes: PUMP_ON=(PUMP), VALVE_ON=(VALVE), ERRO=(FAULT).
//    Latency from Bs rise to PUMP_ON rise = 3 rising edges. PUMP_ON & VALVE_ON never both 1.
//  - IDLE: bs_s -> PUMP; else vs_s -> VALVE; else stay. Both set -> PUMP (pump priority).
//  - PUMP/VALVE: on_cnt cleared on entry, increments each cycle, saturates at MIN_ON.
//    Exit to DEAD when own request low (bs_s for PUMP, vs_s for VALVE) AND on_cnt>=MIN_ON-1;
//    VALVE also exits to DEAD when bs_s=1 under the same on_cnt condition. PUMP ignores vs_s.
//    Net: active state lasts >= MIN_ON cycles.
//  - Flow watchdog in PUMP/VALVE: nf_cnt cleared on entry and whenever flow_s=1; else increments.
//    flow_s=0 with nf_cnt==FLOW_TO-1 -> FAULT (takes priority over exit to DEAD).
//    With FLOW held 0, actuator is on exactly FLOW_TO cycles.
//  - DEAD: all outputs 0; dead_cnt cleared on entry; after DEAD_T cycles -> IDLE. Requests ignored.
//  - FAULT: actuators off next cycle, ERRO=1. CLR=1 -> DEAD (then IDLE); else hold.
//    CLR outside FAULT ignored.
//  - Counter widths $clog2(max+1) of their parameter; no wrap (saturate or state exit first).
//  - Request dropping before MIN_ON: actuator still held to MIN_ON. Request re-rising during DEAD:
//    served from IDLE after DEAD completes. Reset mid-operation: outputs off immediately (async).
// TESTING
//  1 Reset with Bs=Vs=1, FLOW=1 -> all outputs 0 during reset; after release PUMP_ON=1 at 3rd edge.
//  2 FLOW=1, 1-cycle Bs pulse -> PUMP_ON high exactly 8 cycles, then 4 all-off cycles (ST=3),
//    then ST=0.
//  3 FLOW=1, Vs held, Bs rises after 20 cycles of VALVE -> VALVE_ON falls 3 edges later,
//    4 dead cycles, PUMP_ON rises; never overlapping.
//  4 Bs held, FLOW=0 -> PUMP_ON high exactly 16 cycles, then ERRO=1, ST=4; holds 50 cycles;
//    CLR pulse -> ERRO=0 next edge, 4 DEAD cycles, then PUMP restarts.
//  5 FLOW toggles 1/0 every 10 cycles while PUMP -> no fault (nf_cnt never reaches 16).
//  6 Async reset asserted mid-PUMP, mid-DEAD and in FAULT -> outputs 0 and ST=0 without a clock
//    edge.

Source files
------------

// File: rtl/irrigation_actuator_drv.sv
`default_nettype none
// ============================================================================
//  Module      : irrigation_actuator_drv
//  Description : Actuator side of the irrigation command interface. Drives
//                the sprinkler pump and drip valve from level requests,
//                enforcing pump/valve mutual exclusion, minimum on-time,
//                changeover dead-time and a no-flow watchdog fault.
//  Revision    : 1.0  initial release
// ============================================================================
module irrigation_actuator_drv #(
    parameter int MIN_ON  = 8,
    parameter int DEAD_T  = 4,
    parameter int FLOW_TO = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       Bs,
    input  logic       Vs,
    input  logic       FLOW,
    input  logic       CLR,
    output logic       PUMP_ON,
    output logic       VALVE_ON,
    output logic       ERRO,
    output logic [2:0] ST
);

    // Counter widths: wide enough to hold the parameter value itself
    localparam int c_ON_W   = $clog2(MIN_ON + 1);
    localparam int c_NF_W   = $clog2(FLOW_TO + 1);
    localparam int c_DEAD_W = $clog2(DEAD_T + 1);

    localparam logic [c_ON_W-1:0]   c_ON_MAX    = c_ON_W'(MIN_ON);
    localparam logic [c_ON_W-1:0]   c_ON_LAST   = c_ON_W'(MIN_ON - 1);
    localparam logic [c_ON_W-1:0]   c_ON_INC    = c_ON_W'(1);
    localparam logic [c_NF_W-1:0]   c_NF_LAST   = c_NF_W'(FLOW_TO - 1);
    localparam logic [c_NF_W-1:0]   c_NF_INC    = c_NF_W'(1);
    localparam logic [c_DEAD_W-1:0] c_DEAD_LAST = c_DEAD_W'(DEAD_T - 1);
    localparam logic [c_DEAD_W-1:0] c_DEAD_INC  = c_DEAD_W'(1);

    // State encoding doubles as the ST output code
    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_PUMP  = 3'd1;
    localparam logic [2:0] c_ST_VALVE = 3'd2;
    localparam logic [2:0] c_ST_DEAD  = 3'd3;
    localparam logic [2:0] c_ST_FAULT = 3'd4;

    logic                r_bs_meta, r_bs_s;
    logic                r_vs_meta, r_vs_s;
    logic                r_flow_meta, r_flow_s;
    logic [2:0]          r_state;
    logic [2:0]          w_next_state;
    logic [c_ON_W-1:0]   r_on_cnt;
    logic [c_NF_W-1:0]   r_nf_cnt;
    logic [c_DEAD_W-1:0] r_dead_cnt;
    logic                r_pump_on, r_valve_on, r_erro;
    logic                w_min_on_met;
    logic                w_flow_fault;

    assign w_min_on_met = (r_on_cnt >= c_ON_LAST);
    assign w_flow_fault = !r_flow_s && (r_nf_cnt == c_NF_LAST);

    // Two-flop synchronizers for the asynchronous level inputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bs_meta   <= 1'b0;
            r_bs_s      <= 1'b0;
            r_vs_meta   <= 1'b0;
            r_vs_s      <= 1'b0;
            r_flow_meta <= 1'b0;
            r_flow_s    <= 1'b0;
        end else begin
            r_bs_meta   <= Bs;
            r_bs_s      <= r_bs_meta;
            r_vs_meta   <= Vs;
            r_vs_s      <= r_vs_meta;
            r_flow_meta <= FLOW;
            r_flow_s    <= r_flow_meta;
        end
    end

    // Next-state selection; the flow fault outranks a normal exit to DEAD
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (r_bs_s)      w_next_state = c_ST_PUMP;
                else if (r_vs_s) w_next_state = c_ST_VALVE;
            end
            c_ST_PUMP: begin
                if (w_flow_fault)                  w_next_state = c_ST_FAULT;
                else if (!r_bs_s && w_min_on_met) w_next_state = c_ST_DEAD;
            end
            c_ST_VALVE: begin
                if (w_flow_fault)                             w_next_state = c_ST_FAULT;
                else if ((!r_vs_s || r_bs_s) && w_min_on_met) w_next_state = c_ST_DEAD;
            end
            c_ST_DEAD: begin
                if (r_dead_cnt == c_DEAD_LAST) w_next_state = c_ST_IDLE;
            end
            c_ST_FAULT: begin
                if (CLR) w_next_state = c_ST_DEAD;
            end
            default: w_next_state = c_ST_IDLE;
        endcase
    end

    // State register with outputs decoded from the next state so they align with ST
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_ST_IDLE;
            r_pump_on  <= 1'b0;
            r_valve_on <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pump_on  <= (w_next_state == c_ST_PUMP);
            r_valve_on <= (w_next_state == c_ST_VALVE);
            r_erro     <= (w_next_state == c_ST_FAULT);
        end
    end

    // Per-state counters, all cleared on any state change
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_on_cnt   <= '0;
            r_nf_cnt   <= '0;
            r_dead_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_on_cnt   <= '0;
            r_nf_cnt   <= '0;
            r_dead_cnt <= '0;
        end else begin
            case (r_state)
                c_ST_PUMP, c_ST_VALVE: begin
                    if (r_on_cnt != c_ON_MAX) r_on_cnt <= r_on_cnt + c_ON_INC;
                    if (r_flow_s) r_nf_cnt <= '0;
                    else          r_nf_cnt <= r_nf_cnt + c_NF_INC;
                end
                c_ST_DEAD: begin
                    r_dead_cnt <= r_dead_cnt + c_DEAD_INC;
                end
                default: begin
                    r_on_cnt   <= r_on_cnt;
                    r_nf_cnt   <= r_nf_cnt;
                    r_dead_cnt <= r_dead_cnt;
                end
            endcase
        end
    end

    assign PUMP_ON  = r_pump_on;
    assign VALVE_ON = r_valve_on;
    assign ERRO     = r_erro;
    assign ST       = r_state;

endmodule
`default_nettype wire
